flow_ram_rmw_ctrl: RTL and testbench
====================================

// Module: flow_ram_rmw_ctrl
// PURPOSE
//  Per-packet read-modify-write engine for the flow statistics table; sits directly upstream of the dual-QDR SRAM interface.
//  Takes a flow update request (table address, packet length, timestamp), reads the flow word and updates its counters.
//  Writes the word back. Keeps up to 2**INFLIGHT_BITS updates in flight and stalls any request whose address is in flight.
// PARAMETERS
//  ADDR_W         `FLOW_RAM_ADDR_WIDTH  flow table word address width
//  PKT_W          16   packet counter field, word bits [PKT_W-1:0]
//  BYTE_W         32   byte counter field, next BYTE_W bits
//  TS_W           24   last-seen timestamp field, top TS_W bits; PKT_W+BYTE_W+TS_W == `FLOW_RAM_WORD_WIDTH
//  LEN_W          16   packet length input width
//  INFLIGHT_BITS  2    log2 of max updates between accept and write-back issue
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high reset
//  req_valid      in   1       update request present
//  req_ready      out  1       request accepted when req_valid && req_ready
//  req_addr       in   ADDR_W  flow word address
//  req_len        in   LEN_W   packet length in bytes
//  req_ts         in   TS_W    packet timestamp
//  read_ready     in   1       SRAM interface accepts a read this cycle
//  read_en        out  1       read request, = accept
//  read_addr      out  ADDR_W  = req_addr
//  read_data      in   WORD    returned flow word, in request order
//  read_data_new  in   1       read_data valid; cannot be back-pressured
//  write_ready    in   1       SRAM interface accepts a write this cycle
//  write_en       out  1       write-back request
//  write_addr     out  ADDR_W  write-back address
//  write_data     out  WORD    updated flow word
//  err_orphan     out  1       sticky: read_data_new arrived with no pending context
// BEHAVIOUR
//  - Reset: every output is 0, and every FIFO, table and counter is cleared. The FSM goes to INIT.
//  - FSM INIT -> RUN after one cycle. req_ready is 0 in INIT.
//  - req_ready in RUN = read_ready && inflight < 2**INFLIGHT_BITS && !hazard. It is combinational; read_en = req_valid && req_ready.
//  - hazard = req_addr equals the address of any valid in-flight table entry, or of the entry released last cycle (see below).
//  - On accept, push {addr,len,ts} into the in-order context FIFO and set a table entry valid with addr. inflight += 1.
//  - On read_data_new, pop the context FIFO head. Next cycle, push the updated word into the write queue (registered, 1 cycle):
//    pkt += 1; bytes += len (len zero-extended); ts = req ts.
//  - Write queue depth is 2**INFLIGHT_BITS, so it never overflows. Its head drives write_en/write_addr/write_data (fallthrough).
//    An entry pops when write_en && write_ready.
//  - On a write handshake, inflight -= 1 and the matching table entry is cleared. Its address still counts as a hazard for the next cycle,
//    which covers the SRAM interface's internal write register.
//  - Accept and write handshake in the same cycle: inflight is unchanged.
//  - Updates to the same address are therefore serialised: the second read is issued no earlier than 2 cycles after the first write handshake.
//  - read_data_new with an empty context FIFO: the data is dropped and err_orphan is set (cleared only by reset).
//    This covers reads returning after a mid-operation reset.
//  - Best-case latency: accept at T, read_data_new at T+k, write_en at T+k+1.
// CONFIGURATION
//  FLOW_RMW_SATURATE_EN defined: pkt and bytes saturate at all-ones (the carry is dropped and the field is held at max).
//  Not defined: both fields wrap modulo 2**PKT_W and 2**BYTE_W respectively.
// TESTING
//  1. Word 0, req addr=5 len=100 ts=7, read returns 0 -> write addr=5, pkt=1, bytes=100, ts=7, one cycle after read_data_new.
//  2. Back-to-back requests to addr 5 then 6 -> both reads issue on consecutive cycles.
//     Back-to-back requests to addr 5 then 5 -> the second read_en comes no earlier than 2 cycles after the first write handshake;
//     final pkt=2, bytes=sum of both lengths.
//  3. Hold read_data_new off and issue 5 distinct requests -> exactly 4 accepted, req_ready=0 until a write handshake.
//  4. write_ready held 0 for 10 cycles with 4 reads returned -> no data loss; 4 writes in order once write_ready=1.
//  5. Read returns pkt=16'hFFFF, bytes=32'hFFFFFFF0, len=64:
//     with FLOW_RMW_SATURATE_EN -> pkt=FFFF, bytes=FFFFFFFF; without it -> pkt=0, bytes=0x30.
//  6. Reset with 2 reads in flight, then the 2 read_data_new pulses -> no write_en, err_orphan=1.

Source files
------------

// File: rtl/flow_ram_rmw_if.sv
// Request / SRAM-side handshake bundle for the flow table read-modify-write engine.
// master = engine side, slave = requester + SRAM interface side.
`ifndef FLOW_RAM_ADDR_WIDTH
`define FLOW_RAM_ADDR_WIDTH 10
`endif
`ifndef FLOW_RAM_WORD_WIDTH
`define FLOW_RAM_WORD_WIDTH 72
`endif

interface flow_ram_rmw_if #(
  parameter int ADDR_W = `FLOW_RAM_ADDR_WIDTH,
  parameter int WORD_W = `FLOW_RAM_WORD_WIDTH,
  parameter int LEN_W  = 16,
  parameter int TS_W   = 24
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [TS_W-1:0]   req_ts;
  logic              read_ready;
  logic              read_en;
  logic [ADDR_W-1:0] read_addr;
  logic [WORD_W-1:0] read_data;
  logic              read_data_new;
  logic              write_ready;
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [WORD_W-1:0] write_data;

  modport master (
    input  req_valid, req_addr, req_len, req_ts,
    input  read_ready, read_data, read_data_new, write_ready,
    output req_ready, read_en, read_addr, write_en, write_addr, write_data
  );

  modport slave (
    output req_valid, req_addr, req_len, req_ts,
    output read_ready, read_data, read_data_new, write_ready,
    input  req_ready, read_en, read_addr, write_en, write_addr, write_data
  );
endinterface

// File: rtl/flow_ram_rmw_ctrl.sv
// Per-packet read-modify-write engine for the flow statistics table (pkt/bytes/last-ts).
// Define FLOW_RMW_SATURATE_EN to make the pkt and byte counters saturate instead of wrap.
`ifndef FLOW_RAM_ADDR_WIDTH
`define FLOW_RAM_ADDR_WIDTH 10
`endif
`ifndef FLOW_RAM_WORD_WIDTH
`define FLOW_RAM_WORD_WIDTH 72
`endif

module flow_ram_rmw_ctrl #(
  parameter int ADDR_W        = `FLOW_RAM_ADDR_WIDTH,
  parameter int PKT_W         = 16,
  parameter int BYTE_W        = 32,
  parameter int TS_W          = 24,
  parameter int LEN_W         = 16,
  parameter int INFLIGHT_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  flow_ram_rmw_if.master   bus,
  output logic             err_orphan
);
  localparam int WORD_W = PKT_W + BYTE_W + TS_W;
  localparam int DEPTH  = 2**INFLIGHT_BITS;
  localparam int CNT_W  = INFLIGHT_BITS + 1;

  typedef logic [INFLIGHT_BITS-1:0] ptr_t;
  typedef logic [CNT_W-1:0]         cnt_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [TS_W-1:0]   ts;
  } ctx_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] word;
  } wr_t;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t state, state_nxt;
  logic   req_ready, accept, whs, hazard;

  // in-flight table: ring allocated on accept, retired on write handshake (strictly in order)
  logic [DEPTH-1:0]             tbl_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] tbl_addr;
  ptr_t                         tbl_wp, tbl_rp;
  cnt_t                         inflight;
  logic                         rel_vld;
  logic [ADDR_W-1:0]            rel_addr;

  ctx_t ctx_mem [DEPTH];
  ptr_t ctx_wp, ctx_rp;
  cnt_t ctx_cnt;
  logic ctx_pop, orphan;

  wr_t  wq_mem [DEPTH];
  ptr_t wq_wp, wq_rp;
  cnt_t wq_cnt;
  wr_t  wq_head;
  logic wq_nempty;

  ctx_t              hd;
  logic [PKT_W:0]    pkt_sum;
  logic [BYTE_W:0]   byte_sum;
  logic [PKT_W-1:0]  pkt_new;
  logic [BYTE_W-1:0] byte_new;
  logic [WORD_W-1:0] upd_word;
  logic              unused_ts;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      ST_INIT: state_nxt = ST_RUN;
      ST_RUN:  req_ready = bus.read_ready && (inflight < cnt_t'(DEPTH)) && !hazard;
    endcase
  end

  // the just-released address stays hazardous one more cycle for the SRAM write register
  always_comb begin
    hazard = rel_vld && (rel_addr == bus.req_addr);
    for (int i = 0; i < DEPTH; i++)
      if (tbl_vld[i] && (tbl_addr[i] == bus.req_addr)) hazard = 1'b1;
  end

  assign accept        = bus.req_valid && req_ready;
  assign bus.req_ready = req_ready;
  assign bus.read_en   = accept;
  assign bus.read_addr = accept ? bus.req_addr : '0;

  assign wq_nempty      = (wq_cnt != '0);
  assign wq_head        = wq_mem[wq_rp];
  assign bus.write_en   = wq_nempty;
  assign bus.write_addr = wq_nempty ? wq_head.addr : '0;
  assign bus.write_data = wq_nempty ? wq_head.word : '0;
  assign whs            = wq_nempty && bus.write_ready;

  assign ctx_pop = bus.read_data_new && (ctx_cnt != '0);
  assign orphan  = bus.read_data_new && (ctx_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_vld  <= '0;
      tbl_addr <= '0;
      tbl_wp   <= '0;
      tbl_rp   <= '0;
      inflight <= '0;
      rel_vld  <= 1'b0;
      rel_addr <= '0;
    end else begin
      if (accept) begin
        tbl_vld[tbl_wp]  <= 1'b1;
        tbl_addr[tbl_wp] <= bus.req_addr;
        tbl_wp           <= tbl_wp + ptr_t'(1);
      end
      if (whs) begin
        tbl_vld[tbl_rp] <= 1'b0;
        tbl_rp          <= tbl_rp + ptr_t'(1);
      end
      rel_vld  <= whs;
      rel_addr <= whs ? wq_head.addr : '0;
      inflight <= inflight + cnt_t'(accept) - cnt_t'(whs);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctx_mem[i] <= '0;
      ctx_wp     <= '0;
      ctx_rp     <= '0;
      ctx_cnt    <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (accept) begin
        ctx_mem[ctx_wp] <= '{addr: bus.req_addr, len: bus.req_len, ts: bus.req_ts};
        ctx_wp          <= ctx_wp + ptr_t'(1);
      end
      if (ctx_pop) ctx_rp <= ctx_rp + ptr_t'(1);
      ctx_cnt <= ctx_cnt + cnt_t'(accept) - cnt_t'(ctx_pop);
      if (orphan) err_orphan <= 1'b1;
    end
  end

  assign hd       = ctx_mem[ctx_rp];
  assign pkt_sum  = {1'b0, bus.read_data[PKT_W-1:0]} + (PKT_W+1)'(1);
  assign byte_sum = {1'b0, bus.read_data[PKT_W +: BYTE_W]} + (BYTE_W+1)'(hd.len);

`ifdef FLOW_RMW_SATURATE_EN
  assign pkt_new  = pkt_sum[PKT_W]   ? '1 : pkt_sum[PKT_W-1:0];
  assign byte_new = byte_sum[BYTE_W] ? '1 : byte_sum[BYTE_W-1:0];
`else
  assign pkt_new  = pkt_sum[PKT_W-1:0];
  assign byte_new = byte_sum[BYTE_W-1:0];
`endif

  assign upd_word  = {hd.ts, byte_new, pkt_new};
  assign unused_ts = ^bus.read_data[WORD_W-1 -: TS_W];

  // the queue slot itself is the one-cycle update register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) wq_mem[i] <= '0;
      wq_wp  <= '0;
      wq_rp  <= '0;
      wq_cnt <= '0;
    end else begin
      if (ctx_pop) begin
        wq_mem[wq_wp] <= '{addr: hd.addr, word: upd_word};
        wq_wp         <= wq_wp + ptr_t'(1);
      end
      if (whs) wq_rp <= wq_rp + ptr_t'(1);
      wq_cnt <= wq_cnt + cnt_t'(ctx_pop) - cnt_t'(whs);
    end
  end
endmodule

// File: tb/tb_flow_ram_rmw_ctrl.sv
// Directed bench for flow_ram_rmw_ctrl: latency, hazard stall, inflight limit, write backpressure,
// counter overflow and orphan read returns.
module tb_flow_ram_rmw_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic err_orphan;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  flow_ram_rmw_if bus ();

  flow_ram_rmw_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .err_orphan (err_orphan)
  );

  typedef struct packed {
    logic [9:0]  addr;
    logic [71:0] data;
  } wr_rec_t;

  wr_rec_t wr_log [$];

  always @(negedge clk)
    if (!reset && bus.write_en && bus.write_ready)
      wr_log.push_back({bus.write_addr, bus.write_data});

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] wd(input logic [23:0] ts, input logic [31:0] bytes, input logic [15:0] pkt);
    return {ts, bytes, pkt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [9:0] a, input logic [15:0] l, input logic [23:0] t);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_len   = l;
    bus.req_ts    = t;
    #1;
  endtask

  task automatic ret(input logic [71:0] d);
    bus.read_data_new = 1'b1;
    bus.read_data     = d;
    tick();
    bus.read_data_new = 1'b0;
    bus.read_data     = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.read_ready = 1'b1;
    bus.write_ready = 1'b1;
    bus.read_data_new = 1'b0;
    bus.read_data = '0;
    drive_req(1'b0, 10'd0, 16'd0, 24'd0);
    tick();
    tick();

    // reset / INIT: nothing accepted even with a valid request
    reset = 1'b0;
    drive_req(1'b1, 10'd5, 16'd100, 24'd7);
    check("init_rdy", bus.req_ready, 1'b0);
    check("init_rden", bus.read_en, 1'b0);
    check("init_rdaddr", bus.read_addr, 10'd0);
    check("init_wen", bus.write_en, 1'b0);
    check("init_orphan", err_orphan, 1'b0);
    tick();

    // 1: single update, write one cycle after read_data_new
    check("t1_rden", bus.read_en, 1'b1);
    check("t1_rdaddr", bus.read_addr, 10'd5);
    tick();
    drive_req(1'b0, 10'd5, 16'd0, 24'd0);
    bus.read_data_new = 1'b1;
    bus.read_data = '0;
    #1;
    check("t1_wen_early", bus.write_en, 1'b0);
    tick();
    bus.read_data_new = 1'b0;
    check("t1_wen", bus.write_en, 1'b1);
    check("t1_waddr", bus.write_addr, 10'd5);
    check("t1_wdata", bus.write_data, wd(24'd7, 32'd100, 16'd1));
    tick();
    check("t1_wen_done", bus.write_en, 1'b0);
    check("t1_rel_hz5", bus.req_ready, 1'b0);
    drive_req(1'b0, 10'd6, 16'd0, 24'd0);
    check("t1_rel_ok6", bus.req_ready, 1'b1);
    drive_req(1'b0, 10'd5, 16'd0, 24'd0);
    tick();
    check("t1_rel_clr", bus.req_ready, 1'b1);

    // 2a: back-to-back distinct addresses
    wr_log.delete();
    drive_req(1'b1, 10'd5, 16'd1, 24'd1);
    check("t2a_rd0", bus.read_en, 1'b1);
    tick();
    drive_req(1'b1, 10'd6, 16'd2, 24'd2);
    check("t2a_rd1", bus.read_en, 1'b1);
    tick();
    drive_req(1'b0, 10'd0, 16'd0, 24'd0);
    ret('0);
    ret('0);
    tick(); tick(); tick();
    check("t2a_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("t2a_w0", wr_log[0], {10'd5, wd(24'd1, 32'd1, 16'd1)});
      check("t2a_w1", wr_log[1], {10'd6, wd(24'd2, 32'd2, 16'd1)});
    end

    // 2b: same address twice is serialised behind the write-back
    drive_req(1'b1, 10'd5, 16'd10, 24'd1);
    check("t2b_rd0", bus.read_en, 1'b1);
    tick();
    drive_req(1'b1, 10'd5, 16'd20, 24'd2);
    check("t2b_hz_tbl", bus.req_ready, 1'b0);
    bus.read_data_new = 1'b1;
    bus.read_data = '0;
    tick();
    bus.read_data_new = 1'b0;
    check("t2b_w0", bus.write_data, wd(24'd1, 32'd10, 16'd1));
    check("t2b_hz_wq", bus.req_ready, 1'b0);
    tick();
    check("t2b_hz_rel", bus.read_en, 1'b0);
    tick();
    check("t2b_rd1", bus.read_en, 1'b1);
    tick();
    drive_req(1'b0, 10'd0, 16'd0, 24'd0);
    ret(wd(24'd1, 32'd10, 16'd1));
    check("t2b_waddr", bus.write_addr, 10'd5);
    check("t2b_w1", bus.write_data, wd(24'd2, 32'd30, 16'd2));
    tick(); tick(); tick();

    // 3: inflight limit of 4
    wr_log.delete();
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, 10'(20 + i), 16'(10 + i), 24'(100 + i));
      check($sformatf("t3_acc%0d", i), bus.req_ready, 1'b1);
      tick();
    end
    drive_req(1'b1, 10'd24, 16'd14, 24'd104);
    check("t3_full0", bus.req_ready, 1'b0);
    tick();
    check("t3_full1", bus.req_ready, 1'b0);
    ret('0);
    check("t3_wait", bus.req_ready, 1'b0);
    tick();
    check("t3_freed", bus.read_en, 1'b1);
    tick();
    drive_req(1'b0, 10'd0, 16'd0, 24'd0);
    check("t3_nwr", wr_log.size(), 1);
    if (wr_log.size() == 1)
      check("t3_w20", wr_log[0], {10'd20, wd(24'd100, 32'd10, 16'd1)});

    // 4: write backpressure with 4 returned reads
    wr_log.delete();
    bus.write_ready = 1'b0;
    for (int j = 1; j <= 4; j++) ret(wd(24'd0, 32'd0, 16'(j)));
    repeat (10) tick();
    check("t4_hold_wen", bus.write_en, 1'b1);
    check("t4_hold_addr", bus.write_addr, 10'd21);
    check("t4_hold_nwr", wr_log.size(), 0);
    bus.write_ready = 1'b1;
    repeat (5) tick();
    check("t4_drained", bus.write_en, 1'b0);
    check("t4_nwr", wr_log.size(), 4);
    if (wr_log.size() == 4)
      for (int j = 1; j <= 4; j++)
        check($sformatf("t4_w%0d", j), wr_log[j-1],
              {10'(20 + j), wd(24'(100 + j), 32'(10 + j), 16'(j + 1))});
    tick();

    // 5: counter overflow
    drive_req(1'b1, 10'd40, 16'd64, 24'd9);
    check("t5_rd", bus.read_en, 1'b1);
    tick();
    drive_req(1'b0, 10'd0, 16'd0, 24'd0);
    ret(wd(24'd0, 32'hFFFF_FFF0, 16'hFFFF));
`ifdef FLOW_RMW_SATURATE_EN
    check("t5_sat", bus.write_data, wd(24'd9, 32'hFFFF_FFFF, 16'hFFFF));
`else
    check("t5_wrap", bus.write_data, wd(24'd9, 32'h0000_0030, 16'h0000));
`endif
    tick(); tick(); tick();

    // 6: reads returning after a mid-operation reset are orphans
    drive_req(1'b1, 10'd50, 16'd1, 24'd1);
    tick();
    drive_req(1'b1, 10'd51, 16'd1, 24'd1);
    tick();
    drive_req(1'b0, 10'd0, 16'd0, 24'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_orphan_pre", err_orphan, 1'b0);
    ret('0);
    ret('0);
    check("t6_wen", bus.write_en, 1'b0);
    check("t6_orphan", err_orphan, 1'b1);
    tick();
    check("t6_wen_late", bus.write_en, 1'b0);
    check("t6_orphan_sticky", err_orphan, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
